// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the multiplier scheduler.
// No logic, so no latency.
// No flow control; only typedefs and constants live here.
package mult_sched_pkg;

    localparam int BLOCK_LEN   = 64;
    localparam int OP_W        = 16;
    localparam int RES_W       = 32;
    localparam int MAX_CLIENTS = 4;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        KICK,
        DRAIN,
        DONE
    } state_t;

    typedef logic [$clog2(MAX_CLIENTS)-1:0] client_id_t;

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// Round-robin pick of the first requester at or after the priority pointer.
// Purely combinational, zero latency.
// No backpressure; the pointer register is owned by the parent.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [ID_W-1:0] gnt_id_o,
    output logic            gnt_vld_o
);

    // Walk the request vector starting at the pointer, wrapping once.
    always_comb begin
        int             pos;
        logic [ID_W-1:0] idx;
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = ID_W'(pos);
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Time-shares one block multiplier between clients: fill 64 beats, block-read, return tagged products.
// Operand path is combinational pass-through; results appear 1 cycle after VALID_memVal.
// Operand beats stall on client op_valid or RDY_mult; results have no backpressure.
module mult_scheduler #(
    parameter int NUM_CLIENTS = 2,
    parameter int BLOCK_LEN   = mult_sched_pkg::BLOCK_LEN,
    parameter int OP_W        = mult_sched_pkg::OP_W,
    parameter int RES_W       = mult_sched_pkg::RES_W
) (
    input  logic                           CLK,
    input  logic                           rst,
    input  logic [NUM_CLIENTS-1:0]         req,
    input  logic [NUM_CLIENTS-1:0]         op_valid,
    input  logic [NUM_CLIENTS*OP_W-1:0]    op_a,
    input  logic [NUM_CLIENTS*OP_W-1:0]    op_b,
    output logic [NUM_CLIENTS-1:0]         op_ready,
    output logic                           res_valid,
    output logic [RES_W-1:0]               res_data,
    output logic [$clog2(NUM_CLIENTS)-1:0] res_id,
    output logic [NUM_CLIENTS-1:0]         done,
    output logic                           busy,
    output logic                           EN_mult,
    output logic [OP_W-1:0]                mult_input0,
    output logic [OP_W-1:0]                mult_input1,
    input  logic                           RDY_mult,
    output logic                           EN_blockRead,
    input  logic                           VALID_memVal,
    input  logic [RES_W-1:0]               memVal_data
);

    import mult_sched_pkg::*;

    localparam int ID_W  = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(BLOCK_LEN) + 1;

    state_t             state_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               res_valid_q;
    logic [RES_W-1:0]   res_data_q;
    logic [ID_W-1:0]    res_id_q;

    logic [NUM_CLIENTS-1:0] arb_gnt;
    logic [ID_W-1:0]        arb_id;
    logic                   arb_vld;
    logic [NUM_CLIENTS-1:0] gnt_oh;
    logic [OP_W-1:0]        a_arr [NUM_CLIENTS];
    logic [OP_W-1:0]        b_arr [NUM_CLIENTS];
    logic                   in_fill;
    logic                   beat_fire;
    logic                   word_fire;

    rr_arbiter #(
        .N    (NUM_CLIENTS),
        .ID_W (ID_W)
    ) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_id_o  (arb_id),
        .gnt_vld_o (arb_vld)
    );

    for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_unpack
        assign a_arr[c] = op_a[c*OP_W +: OP_W];
        assign b_arr[c] = op_b[c*OP_W +: OP_W];
    end

    // One-hot view of the held grant, used for op_ready and done.
    always_comb begin
        gnt_oh           = '0;
        gnt_oh[gnt_id_q] = 1'b1;
    end

    assign in_fill   = (state_q == FILL);
    assign beat_fire = in_fill && op_valid[gnt_id_q] && RDY_mult;
    assign word_fire = ((state_q == KICK) || (state_q == DRAIN)) && VALID_memVal;

    // Operand beats pass straight through to the multiplier; inputs read as zero when idle.
    always_comb begin
        op_ready    = (in_fill && RDY_mult) ? gnt_oh : '0;
        EN_mult     = beat_fire;
        mult_input0 = beat_fire ? a_arr[gnt_id_q] : '0;
        mult_input1 = beat_fire ? b_arr[gnt_id_q] : '0;
    end

    // Block-read request is held through KICK but dropped in the cycle the first product shows up.
    assign EN_blockRead = (state_q == KICK) && !VALID_memVal;

    assign busy      = in_fill || (state_q == KICK) || (state_q == DRAIN);
    assign done      = (state_q == DONE) ? gnt_oh : '0;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

    // Job sequencing: grant, count operand beats, count returned products, advance rr pointer.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            beat_cnt_q  <= '0;
            word_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_vld && RDY_mult) begin
                        gnt_id_q   <= arb_id;
                        beat_cnt_q <= '0;
                        word_cnt_q <= '0;
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (beat_fire) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
                            state_q <= KICK;
                        end
                    end
                end
                KICK, DRAIN: begin
                    if (word_fire) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= memVal_data;
                        res_id_q    <= gnt_id_q;
                        word_cnt_q  <= word_cnt_q + 1'b1;
                        state_q     <= (word_cnt_q == CNT_W'(BLOCK_LEN - 1)) ? DONE : DRAIN;
                    end
                end
                DONE: begin
                    ptr_q   <= (gnt_id_q == ID_W'(NUM_CLIENTS - 1)) ? '0 : gnt_id_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler with a behavioural block multiplier and client models.
// Each scenario task drives its own stimulus and checks inline.
// Clients and multiplier are modelled cycle by cycle; inputs change 1ns after posedge, outputs sampled at negedge.
module tb_mult_scheduler;

    localparam int N   = 2;
    localparam int BL  = 64;
    localparam int OPW = 16;
    localparam int RW  = 32;

    logic                  CLK = 1'b0;
    logic                  rst;
    logic [N-1:0]          req, op_valid, op_ready, done;
    logic [N*OPW-1:0]      op_a, op_b;
    logic                  res_valid, busy, EN_mult, RDY_mult, EN_blockRead, VALID_memVal;
    logic [RW-1:0]         res_data, memVal_data;
    logic [$clog2(N)-1:0]  res_id;
    logic [OPW-1:0]        mult_input0, mult_input1;

    always #5 CLK = ~CLK;

    mult_scheduler #(.NUM_CLIENTS(N), .BLOCK_LEN(BL), .OP_W(OPW), .RES_W(RW)) dut (
        .CLK(CLK), .rst(rst), .req(req), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .done(done), .busy(busy), .EN_mult(EN_mult), .mult_input0(mult_input0),
        .mult_input1(mult_input1), .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data)
    );

    int total = 0;
    int bad   = 0;

    // client model
    int  idx [N];
    bit  active [N];
    int  drop_beat [N];
    int  mulb [N] = '{2, 3};
    bit  toggle_c1, tog;
    // multiplier model
    logic [RW-1:0] mem [BL];
    int  wr_ptr, rd_ptr;
    bit  streaming;
    int  rdy_low_at, rdy_low_left, gap_word, gap_left, stop_word;
    // observations
    int  cyc;
    int  res_d[$], res_i[$], res_c[$], done_order[$], done_c[$];
    int  en_cnt, en_bad, in_bad, rdy_bad, blk_cnt, blk_bad, busy_at_done;
    int  done_hi [N];

    task automatic clear_obs();
        res_d.delete(); res_i.delete(); res_c.delete(); done_order.delete(); done_c.delete();
        en_cnt = 0; en_bad = 0; in_bad = 0; rdy_bad = 0; blk_cnt = 0; blk_bad = 0; busy_at_done = 0;
        for (int c = 0; c < N; c++) done_hi[c] = 0;
    endtask

    task automatic clear_models();
        req = '0; op_valid = '0; op_a = '0; op_b = '0; RDY_mult = 1'b1;
        VALID_memVal = 1'b0; memVal_data = '0;
        for (int c = 0; c < N; c++) begin
            active[c] = 1'b0; idx[c] = 0; drop_beat[c] = -1;
        end
        toggle_c1 = 1'b0; tog = 1'b0;
        rdy_low_at = -1; rdy_low_left = 0; gap_word = -1; gap_left = 0; stop_word = -1;
        wr_ptr = 0; rd_ptr = 0; streaming = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_models();
        clear_obs();
        repeat (2) @(posedge CLK);
        #1 rst = 1'b0;
    endtask

    task automatic start_job(input int c);
        active[c] = 1'b1;
        idx[c]    = 0;
    endtask

    // Cycle-level client and multiplier models; stops after want_done done pulses or the budget.
    task automatic sim(input int max_cyc, input int want_done);
        for (int k = 0; k < max_cyc; k++) begin
            @(posedge CLK);
            #1;
            if (stop_word >= 0 && streaming && rd_ptr == stop_word) return;
            tog = ~tog;
            for (int c = 0; c < N; c++) begin
                req[c] = active[c] && !(drop_beat[c] >= 0 && idx[c] >= drop_beat[c]);
                op_valid[c] = active[c] && idx[c] < BL && (c != 1 || !toggle_c1 || tog);
                op_a[c*OPW +: OPW] = OPW'(idx[c]);
                op_b[c*OPW +: OPW] = OPW'(mulb[c]);
            end
            if (rdy_low_at >= 0 && wr_ptr == rdy_low_at && rdy_low_left > 0) begin
                RDY_mult = 1'b0;
                rdy_low_left--;
            end else begin
                RDY_mult = 1'b1;
            end
            VALID_memVal = 1'b0;
            if (streaming && rd_ptr < BL) begin
                if (gap_word >= 0 && rd_ptr == gap_word && gap_left > 0) begin
                    gap_left--;
                end else begin
                    VALID_memVal = 1'b1;
                    memVal_data  = mem[rd_ptr];
                end
            end
            @(negedge CLK);
            cyc++;
            if (EN_mult) begin
                en_cnt++;
                if (!RDY_mult || wr_ptr >= BL) en_bad++;
                else mem[wr_ptr] = RW'(mult_input0) * RW'(mult_input1);
                wr_ptr++;
            end else if (mult_input0 != '0 || mult_input1 != '0) begin
                in_bad++;
            end
            if (EN_mult != |(op_ready & op_valid)) en_bad++;
            if ($countones(op_ready) > 1) rdy_bad++;
            for (int c = 0; c < N; c++) begin
                if (op_ready[c] && !RDY_mult) rdy_bad++;
                if (op_ready[c] && op_valid[c]) idx[c]++;
            end
            if (EN_blockRead) begin
                blk_cnt++;
                if (VALID_memVal) blk_bad++;
            end
            if (VALID_memVal && streaming) begin
                rd_ptr++;
                if (rd_ptr == BL) begin
                    streaming = 1'b0; rd_ptr = 0; wr_ptr = 0;
                end
            end else if (EN_blockRead && !streaming) begin
                streaming = 1'b1;
            end
            if (res_valid) begin
                res_d.push_back(int'(res_data));
                res_i.push_back(int'(res_id));
                res_c.push_back(cyc);
            end
            for (int c = 0; c < N; c++) begin
                if (done[c]) begin
                    done_hi[c]++;
                    done_order.push_back(c);
                    done_c.push_back(cyc);
                    if (busy) busy_at_done++;
                    active[c] = 1'b0;
                end
            end
            if (done_order.size() >= want_done) return;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; op_valid = '1; op_a = '1; op_b = '1;
        RDY_mult = 1'b1; VALID_memVal = 1'b1; memVal_data = 32'hDEAD_BEEF;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({op_ready, res_valid, res_data, res_id, done, busy, EN_mult, mult_input0, mult_input1, EN_blockRead} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got op_ready=%b res_valid=%b res_data=%h busy=%b EN_mult=%b EN_blockRead=%b expected all zero",
                     op_ready, res_valid, res_data, busy, EN_mult, EN_blockRead);
        end
        rst = 1'b0; req = '0; op_valid = '0; op_a = '0; op_b = '0;
        // stray product valids in IDLE must be ignored
        repeat (3) begin
            @(negedge CLK);
            total++;
            if (res_valid !== 1'b0 || busy !== 1'b0 || EN_blockRead !== 1'b0) begin
                bad++;
                $display("FAIL stray_valid_idle: got res_valid=%b busy=%b EN_blockRead=%b expected 0 0 0", res_valid, busy, EN_blockRead);
            end
        end
        VALID_memVal = 1'b0; req = 2'b01; RDY_mult = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            total++;
            if (busy !== 1'b0 || op_ready !== 2'b00) begin
                bad++;
                $display("FAIL rdy_gating: got busy=%b op_ready=%b expected 0 00", busy, op_ready);
            end
        end
        RDY_mult = 1'b1;
        @(negedge CLK);
        total++;
        if (busy !== 1'b1 || op_ready !== 2'b01) begin
            bad++;
            $display("FAIL first_grant: got busy=%b op_ready=%b expected 1 01", busy, op_ready);
        end
    endtask

    task automatic test_single_client0();
        do_reset();
        start_job(0);
        sim(1000, 1);
        total++;
        if (done_order.size() != 1 || done_order[0] != 0) begin
            bad++; $display("FAIL single_done: got count=%0d expected one done for client 0", done_order.size());
        end
        total++;
        if (res_d.size() != BL) begin
            bad++; $display("FAIL single_res_count: got %0d expected %0d", res_d.size(), BL);
        end
        for (int i = 0; i < res_d.size() && i < BL; i++) begin
            total++;
            if (res_d[i] != 2 * i || res_i[i] != 0) begin
                bad++; $display("FAIL single_word%0d: got data=%0d id=%0d expected data=%0d id=0", i, res_d[i], res_i[i], 2 * i);
            end
        end
        total++;
        if (en_cnt != BL || en_bad != 0 || in_bad != 0 || rdy_bad != 0) begin
            bad++; $display("FAIL single_beats: got en=%0d en_bad=%0d in_bad=%0d rdy_bad=%0d expected 64 0 0 0", en_cnt, en_bad, in_bad, rdy_bad);
        end
        total++;
        if (blk_cnt < 1 || blk_bad != 0) begin
            bad++; $display("FAIL single_blockread: got cycles=%0d overlap=%0d expected >=1 and 0", blk_cnt, blk_bad);
        end
        total++;
        if (done_hi[0] != 1 || busy_at_done != 0) begin
            bad++; $display("FAIL single_done_pulse: got done_cycles=%0d busy_at_done=%0d expected 1 0", done_hi[0], busy_at_done);
        end
        @(posedge CLK);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 2'b00 || op_ready !== 2'b00) begin
            bad++; $display("FAIL single_after: got busy=%b done=%b op_ready=%b expected 0 00 00", busy, done, op_ready);
        end
    endtask

    task automatic test_both_req();
        do_reset();
        start_job(0);
        start_job(1);
        sim(2000, 2);
        total++;
        if (done_order.size() != 2 || done_order[0] != 0 || done_order[1] != 1 || done_c[0] >= done_c[1]) begin
            bad++; $display("FAIL both_order: got count=%0d expected done[0] then done[1]", done_order.size());
        end
        total++;
        if (res_d.size() != 2 * BL || en_cnt != 2 * BL) begin
            bad++; $display("FAIL both_counts: got res=%0d beats=%0d expected 128 128", res_d.size(), en_cnt);
        end
        for (int i = 0; i < res_d.size() && i < 2 * BL; i++) begin
            int c = (i < BL) ? 0 : 1;
            int k = i % BL;
            total++;
            if (res_d[i] != k * mulb[c] || res_i[i] != c) begin
                bad++; $display("FAIL both_word%0d: got data=%0d id=%0d expected data=%0d id=%0d", i, res_d[i], res_i[i], k * mulb[c], c);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        toggle_c1 = 1'b1; rdy_low_at = 20; rdy_low_left = 5;
        start_job(1);
        sim(2000, 1);
        total++;
        if (done_order.size() != 1 || done_order[0] != 1) begin
            bad++; $display("FAIL stall_done: got count=%0d expected one done for client 1", done_order.size());
        end
        total++;
        if (en_cnt != BL || en_bad != 0 || rdy_bad != 0 || in_bad != 0) begin
            bad++; $display("FAIL stall_beats: got en=%0d en_bad=%0d rdy_bad=%0d in_bad=%0d expected 64 0 0 0", en_cnt, en_bad, rdy_bad, in_bad);
        end
        total++;
        if (res_d.size() != BL) begin
            bad++; $display("FAIL stall_res_count: got %0d expected %0d", res_d.size(), BL);
        end
        for (int i = 0; i < res_d.size() && i < BL; i++) begin
            total++;
            if (res_d[i] != 3 * i || res_i[i] != 1) begin
                bad++; $display("FAIL stall_word%0d: got data=%0d id=%0d expected data=%0d id=1", i, res_d[i], res_i[i], 3 * i);
            end
        end
    endtask

    task automatic test_gap();
        do_reset();
        gap_word = 10; gap_left = 3;
        start_job(0);
        sim(1000, 1);
        total++;
        if (res_d.size() != BL) begin
            bad++; $display("FAIL gap_res_count: got %0d expected %0d", res_d.size(), BL);
        end else begin
            total++;
            if (res_c[9] - res_c[8] != 1 || res_c[10] - res_c[9] != 4 || res_c[11] - res_c[10] != 1) begin
                bad++; $display("FAIL gap_spacing: got %0d %0d %0d expected 1 4 1",
                                res_c[9] - res_c[8], res_c[10] - res_c[9], res_c[11] - res_c[10]);
            end
            total++;
            if (res_d[10] != 20 || res_d[63] != 126) begin
                bad++; $display("FAIL gap_data: got w10=%0d w63=%0d expected 20 126", res_d[10], res_d[63]);
            end
            total++;
            if (done_c.size() != 1 || done_c[0] < res_c[63]) begin
                bad++; $display("FAIL gap_done_time: got done_count=%0d expected one done at or after cycle %0d", done_c.size(), res_c[63]);
            end
        end
    endtask

    task automatic test_rst_drain();
        do_reset();
        stop_word = 20;
        start_job(0);
        sim(1000, 1);
        total++;
        if (!streaming || rd_ptr != 20) begin
            bad++; $display("FAIL rst_reach_drain: got streaming=%0d word=%0d expected 1 20", streaming, rd_ptr);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({op_ready, res_valid, res_data, res_id, done, busy, EN_mult, mult_input0, mult_input1, EN_blockRead} !== '0) begin
            bad++; $display("FAIL rst_drain_outputs: got res_valid=%b res_data=%h busy=%b EN_blockRead=%b expected all zero",
                            res_valid, res_data, busy, EN_blockRead);
        end
        total++;
        if (done_order.size() != 0) begin
            bad++; $display("FAIL rst_no_done: got %0d done pulses expected 0", done_order.size());
        end
        clear_models();
        @(posedge CLK);
        #1 rst = 1'b0;
        clear_obs();
        start_job(0);
        sim(1000, 1);
        total++;
        if (done_order.size() != 1 || done_order[0] != 0 || res_d.size() != BL || en_cnt != BL) begin
            bad++; $display("FAIL rst_rerun: got done=%0d res=%0d beats=%0d expected 1 64 64", done_order.size(), res_d.size(), en_cnt);
        end else begin
            total++;
            if (res_d[0] != 0 || res_d[20] != 40 || res_d[63] != 126) begin
                bad++; $display("FAIL rst_rerun_data: got %0d %0d %0d expected 0 40 126", res_d[0], res_d[20], res_d[63]);
            end
        end
    endtask

    task automatic test_drop_req();
        do_reset();
        drop_beat[0] = 30;
        start_job(0);
        start_job(1);
        sim(2000, 2);
        total++;
        if (done_order.size() != 2 || done_order[0] != 0 || done_order[1] != 1) begin
            bad++; $display("FAIL drop_order: got count=%0d expected done[0] then done[1]", done_order.size());
        end
        total++;
        if (res_d.size() != 2 * BL) begin
            bad++; $display("FAIL drop_res_count: got %0d expected %0d", res_d.size(), 2 * BL);
        end else begin
            total++;
            if (res_i[63] != 0 || res_i[64] != 1 || res_d[30] != 60 || res_d[63] != 126 || res_d[69] != 15) begin
                bad++; $display("FAIL drop_data: got id63=%0d id64=%0d w30=%0d w63=%0d w69=%0d expected 0 1 60 126 15",
                                res_i[63], res_i[64], res_d[30], res_d[63], res_d[69]);
            end
        end
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1;
        clear_models();
        clear_obs();
        test_reset();
        test_single_client0();
        test_both_req();
        test_stall();
        test_gap();
        test_rst_drain();
        test_drop_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2ms expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
